dsdac_reg_writer: RTL

Host-side transmitter for the delta-sigma DAC's byte-wide register-write port. It takes a 16-bit register write request through a valid/ready handshake. It then sequences the data byte bus, the 3-bit address and the data_part strobe so that the DAC's synchronized receiver first latches the low byte on a data_part fall, then commits the full word on a data_part rise. It sits in the FPGA/MCU-side test harness that drives the DAC tile's ui_in/uio_in pins.

---
 rtl/dsdac_reg_writer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dsdac_reg_writer.sv
// Host-side transmitter for the delta-sigma DAC byte-wide register-write port.
// Optional echo acknowledge with timeout is enabled by defining ECHO_ACK_EN.
module dsdac_reg_writer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned ECHO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_data,
  output logic [7:0]  data_out,
  output logic [2:0]  addr_out,
  output logic        data_part_out,
  output logic        echo_out,
  input  logic        echo_in,
  output logic        busy,
  output logic        ack_timeout
);

  localparam int unsigned SH_MAX  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_MAX = (SH_MAX > ECHO_TIMEOUT) ? SH_MAX : ECHO_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LO_SETUP,
    LO_HOLD,
    HI_SETUP,
    HI_HOLD
`ifdef ECHO_ACK_EN
    , ECHO_WAIT
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    data_d;
  logic [2:0]    addr_d;
  logic          dp_d;
  logic          rdy_d;

`ifdef ECHO_ACK_EN
  localparam logic [CW-1:0] TO_LD = CW'(ECHO_TIMEOUT - 1);
  logic [1:0] echo_sync_q;
  logic       echo_d;
  logic       ack_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      data_out      <= '0;
      addr_out      <= '0;
      data_part_out <= 1'b1;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      data_out      <= data_d;
      addr_out      <= addr_d;
      data_part_out <= dp_d;
      req_ready     <= rdy_d;
      busy          <= ~rdy_d;
    end
  end

`ifdef ECHO_ACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_sync_q <= '0;
      echo_out    <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      echo_sync_q <= {echo_sync_q[0], echo_in};
      echo_out    <= echo_d;
      ack_timeout <= ack_d;
    end
  end
`else
  logic unused_echo_in;
  assign unused_echo_in = echo_in;
  assign echo_out       = 1'b0;
  assign ack_timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    data_d  = data_out;
    addr_d  = addr_out;
    dp_d    = data_part_out;
    rdy_d   = req_ready;
`ifdef ECHO_ACK_EN
    echo_d  = echo_out;
    ack_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        dp_d  = 1'b1;
        if (req_valid && req_ready) begin
          hi_d    = req_data[15:8];
          data_d  = req_data[7:0];
          addr_d  = req_addr;
          rdy_d   = 1'b0;
          cnt_d   = SETUP_LD;
          state_d = LO_SETUP;
        end
      end
      LO_SETUP: begin
        if (cnt_q == '0) begin
          dp_d    = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = LO_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LO_HOLD: begin
        if (cnt_q == '0) begin
          data_d  = hi_q;
          cnt_d   = SETUP_LD;
          state_d = HI_SETUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HI_SETUP: begin
        if (cnt_q == '0) begin
          dp_d    = 1'b1;
`ifdef ECHO_ACK_EN
          echo_d  = ~echo_out;
`endif
          cnt_d   = HOLD_LD;
          state_d = HI_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HI_HOLD: begin
        if (cnt_q == '0) begin
`ifdef ECHO_ACK_EN
          cnt_d   = TO_LD;
          state_d = ECHO_WAIT;
`else
          rdy_d   = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef ECHO_ACK_EN
      // Match wins over timeout when both happen in the same cycle.
      ECHO_WAIT: begin
        if (echo_sync_q[1] == echo_out) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          rdy_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule
